// File: rtl/alu_vr_if.sv
// alu_vr_if: operand/opcode/result bundle for the registered 3-operand ALU.
// Signals: a, b, c (16-bit operands), s (4-bit opcode), d (16-bit result), e (32-bit wide result).
// Modports: master drives operands/opcode and observes results; slave is the ALU side.
interface alu_vr_if;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;
  logic [3:0]  s;
  logic [15:0] d;
  logic [31:0] e;

  modport master (output a, b, c, s, input d, e);
  modport slave  (input a, b, c, s, output d, e);
endinterface

// File: rtl/alu_vr.sv
// alu_vr: 16-bit, 3-operand registered ALU with 14 functions selected by a 4-bit opcode.
// Ports: clk (rising edge), rst (sync, active-high), alu_io (slave side of alu_vr_if:
//        a/b/c/s in, d = low 16 bits of result, e = 32-bit wide result); latency 1 cycle, no stall.
module alu_vr (
  input  logic           clk,
  input  logic           rst,
  alu_vr_if.slave        alu_io
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_MUL  = 4'b0010,
    OP_MAC  = 4'b0011,
    OP_AND  = 4'b0100,
    OP_OR   = 4'b0101,
    OP_XOR  = 4'b0110,
    OP_NOT  = 4'b0111,
    OP_SHL  = 4'b1000,
    OP_SHR  = 4'b1001,
    OP_INC  = 4'b1010,
    OP_DEC  = 4'b1011,
    OP_RSV0 = 4'b1100,
    OP_RSV1 = 4'b1101,
    OP_ADD3 = 4'b1110,
    OP_MUX  = 4'b1111
  } op_e;

  // Every opcode defines d as e[15:0], so only the wide result is stored.
  logic [31:0] e_q;
  logic [31:0] e_d;

  logic [31:0] a_ext;
  logic [31:0] b_ext;
  logic [31:0] c_ext;
  logic [31:0] prod;
  logic [15:0] mux_res;
  logic [3:0]  shamt;

  assign a_ext   = {16'h0000, alu_io.a};
  assign b_ext   = {16'h0000, alu_io.b};
  assign c_ext   = {16'h0000, alu_io.c};
  assign prod    = a_ext * b_ext;
  assign mux_res = (alu_io.a & alu_io.c) | (alu_io.b & ~alu_io.c);
  // Only the low nibble of b shifts; upper bits are deliberately ignored.
  assign shamt   = alu_io.b[3:0];

  always_comb begin
    e_d = e_q;
    case (op_e'(alu_io.s))
      OP_ADD:  e_d = a_ext + b_ext;
      // 32-bit wrap gives the all-ones upper half when a < b.
      OP_SUB:  e_d = a_ext - b_ext;
      OP_MUL:  e_d = prod;
      OP_MAC:  e_d = prod + c_ext;
      OP_AND:  e_d = {16'h0000, alu_io.a & alu_io.b};
      OP_OR:   e_d = {16'h0000, alu_io.a | alu_io.b};
      OP_XOR:  e_d = {16'h0000, alu_io.a ^ alu_io.b};
      OP_NOT:  e_d = {16'h0000, ~alu_io.a};
      // Shift in the 32-bit domain so bits leaving d land in e[30:16].
      OP_SHL:  e_d = a_ext << shamt;
      OP_SHR:  e_d = {16'h0000, alu_io.a >> shamt};
      OP_INC:  e_d = a_ext + 32'd1;
      OP_DEC:  e_d = a_ext - 32'd1;
      // Reserved codes hold the previous result.
      OP_RSV0: e_d = e_q;
      OP_RSV1: e_d = e_q;
      OP_ADD3: e_d = a_ext + b_ext + c_ext;
      OP_MUX:  e_d = {16'h0000, mux_res};
      default: e_d = e_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= 32'h0000_0000;
    end else begin
      e_q <= e_d;
    end
  end

  assign alu_io.e = e_q;
  assign alu_io.d = e_q[15:0];

endmodule

// File: tb/tb_alu_vr.sv
// tb_alu_vr: directed-vector bench for alu_vr with hand-computed expected results.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 time unit after the next edge.
module tb_alu_vr;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  alu_vr_if alu_io ();

  alu_vr dut (
    .clk    (clk),
    .rst    (rst),
    .alu_io (alu_io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Apply one operation, clock it in, then check both result ports.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [15:0] av, input logic [15:0] bv, input logic [15:0] cv,
                        input logic [15:0] exp_d, input logic [31:0] exp_e);
    alu_io.s = op;
    alu_io.a = av;
    alu_io.b = bv;
    alu_io.c = cv;
    @(posedge clk);
    #1;
    check_val({tag, "_d"}, {16'h0000, alu_io.d}, {16'h0000, exp_d});
    check_val({tag, "_e"}, alu_io.e, exp_e);
  endtask

  localparam logic [15:0] A0 = 16'h2948;
  localparam logic [15:0] B0 = 16'h1234;
  localparam logic [15:0] C0 = 16'h762D;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    alu_io.s = 4'b0010;
    alu_io.a = 16'hBEEF;
    alu_io.b = 16'hCAFE;
    alu_io.c = 16'h1357;

    // Reset held for two edges with arbitrary inputs.
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_val("rst_d", {16'h0000, alu_io.d}, 32'h0000_0000);
    check_val("rst_e", alu_io.e, 32'h0000_0000);

    rst = 1'b0;
    run_op("rsv_after_rst", 4'b1100, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, 32'h0000_0000);

    // Arithmetic sweep.
    run_op("add",  4'b0000, A0, B0, C0, 16'h3B7C, 32'h0000_3B7C);
    run_op("sub",  4'b0001, A0, B0, C0, 16'h1714, 32'h0000_1714);
    run_op("mul",  4'b0010, A0, B0, C0, 16'h72A0, 32'h02EF_72A0);
    run_op("mac",  4'b0011, A0, B0, C0, 16'hE8CD, 32'h02EF_E8CD);
    run_op("add3", 4'b1110, A0, B0, C0, 16'hB1A9, 32'h0000_B1A9);

    // Logic and shifts.
    run_op("and",  4'b0100, A0, B0, C0, 16'h0000, 32'h0000_0000);
    run_op("or",   4'b0101, A0, B0, C0, 16'h3B7C, 32'h0000_3B7C);
    run_op("xor",  4'b0110, A0, B0, C0, 16'h3B7C, 32'h0000_3B7C);
    run_op("not",  4'b0111, A0, B0, C0, 16'hD6B7, 32'h0000_D6B7);
    run_op("shl",  4'b1000, A0, B0, C0, 16'h9480, 32'h0002_9480);
    run_op("shr",  4'b1001, A0, B0, C0, 16'h0294, 32'h0000_0294);
    // (a&c)=2008, (b&~c)=0010 -> 2018
    run_op("mux",  4'b1111, A0, B0, C0, 16'h2018, 32'h0000_2018);

    // Boundaries.
    run_op("add_carry", 4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 32'h0001_0000);
    run_op("sub_borrow", 4'b0001, 16'h1234, 16'h2948, 16'h0000, 16'hE8EC, 32'hFFFF_E8EC);
    run_op("dec_zero", 4'b1011, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 32'hFFFF_FFFF);
    run_op("inc_max",  4'b1010, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 32'h0001_0000);
    run_op("shl_upper_ignored", 4'b1000, 16'h8001, 16'hFFF1, 16'h0000, 16'h0002, 32'h0001_0002);
    run_op("shl_zero", 4'b1000, 16'hA5C3, 16'h0010, 16'h0000, 16'hA5C3, 32'h0000_A5C3);
    run_op("shr_max",  4'b1001, 16'h8000, 16'h000F, 16'h0000, 16'h0001, 32'h0000_0001);
    run_op("mac_wrap", 4'b0011, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 32'hFFFF_0000);
    run_op("add3_max", 4'b1110, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFD, 32'h0002_FFFD);

    // Reserved opcodes hold the previous result.
    run_op("hold_add",  4'b0000, A0, B0, C0, 16'h3B7C, 32'h0000_3B7C);
    run_op("hold_rsv0", 4'b1100, 16'h1111, 16'h2222, 16'h3333, 16'h3B7C, 32'h0000_3B7C);
    run_op("hold_rsv1", 4'b1101, 16'h4444, 16'h5555, 16'h6666, 16'h3B7C, 32'h0000_3B7C);

    // Reset in the middle of a MUL stream, then resume.
    run_op("mul_pre_rst", 4'b0010, A0, B0, C0, 16'h72A0, 32'h02EF_72A0);
    rst = 1'b1;
    run_op("mul_in_rst",  4'b0010, A0, B0, C0, 16'h0000, 32'h0000_0000);
    rst = 1'b0;
    run_op("mul_post_rst", 4'b0010, 16'h0100, 16'h0300, C0, 16'h0000, 32'h0003_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
